// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Brief    : ID-stage decode fields in, pipeline stall/flush/forward controls out
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic [4:0]       id_rd;
  logic             id_reg_we;
  logic             id_mem_rd;
  logic             br_taken;
  logic             stall;
  logic             bubble_ex;
  logic             flush_if_id;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_reg_we, id_mem_rd, br_taken,
    input  stall, bubble_ex, flush_if_id, fwd_a, fwd_b, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_reg_we, id_mem_rd, br_taken,
    output stall, bubble_ex, flush_if_id, fwd_a, fwd_b, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Load-use stall, branch flush and operand forwarding for a 5-stage pipe
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int LOAD_USE_STALL = 1,
  parameter int CNT_W          = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [1:0] C_STALL_RELOAD = 2'(LOAD_USE_STALL - 1);
  localparam bit         C_MULTI_STALL  = (LOAD_USE_STALL > 1);
  localparam logic [1:0] C_FWD_RF       = 2'b00;
  localparam logic [1:0] C_FWD_EX       = 2'b01;
  localparam logic [1:0] C_FWD_MEM      = 2'b10;
  localparam logic [1:0] C_FWD_WB       = 2'b11;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_STALL = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Load flag is only needed in EX: by MEM the loaded value is forwardable.
  logic             ex_v_q, ex_v_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_we_q, ex_we_d;
  logic             ex_ld_q, ex_ld_d;
  logic             mem_v_q, mem_v_d;
  logic [4:0]       mem_rd_q, mem_rd_d;
  logic             mem_we_q, mem_we_d;
  logic             wb_v_q, wb_v_d;
  logic [4:0]       wb_rd_q, wb_rd_d;
  logic             wb_we_q, wb_we_d;

  logic             w_br;
  logic             w_ex_m1, w_ex_m2;
  logic             w_mem_m1, w_mem_m2;
  logic             w_wb_m1, w_wb_m2;
  logic             w_hazard;
  logic             w_stall;
  logic             w_bubble;
  logic             w_flush;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  function automatic logic f_match(input logic v, input logic we,
                                   input logic [4:0] rd, input logic [4:0] rs);
    return v && we && (rd == rs) && (rs != 5'd0);
  endfunction

  // An EX match on a load blocks older stages too: the load's value is the newest.
  function automatic logic [1:0] f_fwd_sel(input logic valid, input logic ex_m,
                                           input logic ex_ld, input logic mem_m,
                                           input logic wb_m);
    logic [1:0] sel;
    sel = C_FWD_RF;
    if (!valid)        sel = C_FWD_RF;
    else if (ex_m)     sel = ex_ld ? C_FWD_RF : C_FWD_EX;
    else if (mem_m)    sel = C_FWD_MEM;
    else if (wb_m)     sel = C_FWD_WB;
    return sel;
  endfunction

  always_comb begin
    w_ex_m1  = f_match(ex_v_q,  ex_we_q,  ex_rd_q,  bus.id_rs1);
    w_ex_m2  = f_match(ex_v_q,  ex_we_q,  ex_rd_q,  bus.id_rs2);
    w_mem_m1 = f_match(mem_v_q, mem_we_q, mem_rd_q, bus.id_rs1);
    w_mem_m2 = f_match(mem_v_q, mem_we_q, mem_rd_q, bus.id_rs2);
    w_wb_m1  = f_match(wb_v_q,  wb_we_q,  wb_rd_q,  bus.id_rs1);
    w_wb_m2  = f_match(wb_v_q,  wb_we_q,  wb_rd_q,  bus.id_rs2);
    w_hazard = bus.id_valid && ex_ld_q && (w_ex_m1 || w_ex_m2);
    w_fwd_a  = f_fwd_sel(bus.id_valid, w_ex_m1, ex_ld_q, w_mem_m1, w_wb_m1);
    w_fwd_b  = f_fwd_sel(bus.id_valid, w_ex_m2, ex_ld_q, w_mem_m2, w_wb_m2);
  end

  // br_taken is masked during reset so every control output is quiet while rst=1.
  always_comb begin
    w_br     = bus.br_taken && !rst;
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (w_br) begin
      w_flush  = 1'b1;
      w_bubble = 1'b1;
      state_d  = S_RUN;
      cnt_d    = 2'd0;
    end else if (state_q == S_STALL) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      cnt_d    = cnt_q - 2'd1;
      if (cnt_q == 2'd1) begin
        state_d = S_RUN;
      end
    end else if (w_hazard) begin
      w_stall  = 1'b1;
      w_bubble = 1'b1;
      if (C_MULTI_STALL) begin
        state_d = S_STALL;
        cnt_d   = C_STALL_RELOAD;
      end
    end
  end

  always_comb begin
    ex_v_d   = bus.id_valid && !w_bubble;
    ex_rd_d  = bus.id_rd;
    ex_we_d  = bus.id_reg_we;
    ex_ld_d  = bus.id_mem_rd;
    mem_v_d  = ex_v_q;
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    wb_v_d   = mem_v_q;
    wb_rd_d  = mem_rd_q;
    wb_we_d  = mem_we_q;
    stall_cnt_d = stall_cnt_q;
    if (w_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      cnt_q       <= 2'd0;
      stall_cnt_q <= '0;
      ex_v_q      <= 1'b0;
      ex_rd_q     <= 5'd0;
      ex_we_q     <= 1'b0;
      ex_ld_q     <= 1'b0;
      mem_v_q     <= 1'b0;
      mem_rd_q    <= 5'd0;
      mem_we_q    <= 1'b0;
      wb_v_q      <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_we_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
      ex_v_q      <= ex_v_d;
      ex_rd_q     <= ex_rd_d;
      ex_we_q     <= ex_we_d;
      ex_ld_q     <= ex_ld_d;
      mem_v_q     <= mem_v_d;
      mem_rd_q    <= mem_rd_d;
      mem_we_q    <= mem_we_d;
      wb_v_q      <= wb_v_d;
      wb_rd_q     <= wb_rd_d;
      wb_we_q     <= wb_we_d;
    end
  end

  assign bus.stall       = w_stall;
  assign bus.bubble_ex   = w_bubble;
  assign bus.flush_if_id = w_flush;
  assign bus.fwd_a       = w_fwd_a;
  assign bus.fwd_b       = w_fwd_b;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Directed checks of forwarding, load-use stall, flush and reset
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic       id_reg_we = 1'b0, id_mem_rd = 1'b0, br_taken = 1'b0;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  // One DUT per load-use stall depth, all fed the same stimulus.
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus1 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus2 ();
  pipe_hazard_ctrl_if #(.CNT_W(16)) bus3 ();

  assign bus1.id_valid = id_valid;  assign bus2.id_valid = id_valid;  assign bus3.id_valid = id_valid;
  assign bus1.id_rs1 = id_rs1;      assign bus2.id_rs1 = id_rs1;      assign bus3.id_rs1 = id_rs1;
  assign bus1.id_rs2 = id_rs2;      assign bus2.id_rs2 = id_rs2;      assign bus3.id_rs2 = id_rs2;
  assign bus1.id_rd = id_rd;        assign bus2.id_rd = id_rd;        assign bus3.id_rd = id_rd;
  assign bus1.id_reg_we = id_reg_we; assign bus2.id_reg_we = id_reg_we; assign bus3.id_reg_we = id_reg_we;
  assign bus1.id_mem_rd = id_mem_rd; assign bus2.id_mem_rd = id_mem_rd; assign bus3.id_mem_rd = id_mem_rd;
  assign bus1.br_taken = br_taken;  assign bus2.br_taken = br_taken;  assign bus3.br_taken = br_taken;

  pipe_hazard_ctrl #(.LOAD_USE_STALL(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  pipe_hazard_ctrl #(.LOAD_USE_STALL(2), .CNT_W(16)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  pipe_hazard_ctrl #(.LOAD_USE_STALL(3), .CNT_W(16)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic we, input logic ld);
    id_valid  = v;
    id_rs1    = rs1;
    id_rs2    = rs2;
    id_rd     = rd;
    id_reg_we = we;
    id_mem_rd = ld;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    br_taken = 1'b0;
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    br_taken = 1'b1;
    set_id(1'b1, 5'd5, 5'd5, 5'd5, 1'b1, 1'b1);
    next_cycle();
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b expected 0", bus1.stall); end
    checks++; if (bus1.bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_bubble: got %0b expected 0", bus1.bubble_ex); end
    checks++; if (bus1.flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_flush: got %0b expected 0", bus1.flush_if_id); end
    checks++; if ({bus1.fwd_a, bus1.fwd_b} !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b%b expected 0000", bus1.fwd_a, bus1.fwd_b); end
    checks++; if (bus1.stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", bus1.stall_cnt); end
    br_taken = 1'b0;
  endtask

  task automatic test_alu_chain();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (bus1.fwd_a !== 2'b01) begin errors++; $display("FAIL alu_fwd_ex: got %b expected 01", bus1.fwd_a); end
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL alu_nostall: got %0b expected 0", bus1.stall); end
    next_cycle();
    set_id(1'b1, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus1.fwd_b !== 2'b10) begin errors++; $display("FAIL alu_fwd_mem: got %b expected 10", bus1.fwd_b); end
    checks++; if (bus1.fwd_a !== 2'b00) begin errors++; $display("FAIL alu_x0_a: got %b expected 00", bus1.fwd_a); end
    next_cycle();
    set_id(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus1.fwd_a !== 2'b11) begin errors++; $display("FAIL alu_fwd_wb: got %b expected 11", bus1.fwd_a); end
    set_id(1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus1.fwd_a, bus1.fwd_b} !== 4'b0000) begin errors++; $display("FAIL alu_invalid_fwd: got %b%b expected 0000", bus1.fwd_a, bus1.fwd_b); end
  endtask

  task automatic test_load_use_1();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (bus1.stall !== 1'b1) begin errors++; $display("FAIL lu1_stall: got %0b expected 1", bus1.stall); end
    checks++; if (bus1.bubble_ex !== 1'b1) begin errors++; $display("FAIL lu1_bubble: got %0b expected 1", bus1.bubble_ex); end
    checks++; if (bus1.fwd_a !== 2'b00) begin errors++; $display("FAIL lu1_fwd_blocked: got %b expected 00", bus1.fwd_a); end
    next_cycle();
    #1;
    checks++; if (bus1.stall !== 1'b0) begin errors++; $display("FAIL lu1_release: got %0b expected 0", bus1.stall); end
    checks++; if (bus1.fwd_a !== 2'b10) begin errors++; $display("FAIL lu1_fwd_mem: got %b expected 10", bus1.fwd_a); end
    checks++; if (bus1.stall_cnt !== 16'd1) begin errors++; $display("FAIL lu1_cnt: got %0d expected 1", bus1.stall_cnt); end
  endtask

  task automatic test_load_use_2();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (bus2.stall !== 1'b1) begin errors++; $display("FAIL lu2_stall1: got %0b expected 1", bus2.stall); end
    next_cycle();
    #1;
    checks++; if ({bus2.stall, bus2.bubble_ex} !== 2'b11) begin errors++; $display("FAIL lu2_stall2: got %b expected 11", {bus2.stall, bus2.bubble_ex}); end
    next_cycle();
    #1;
    checks++; if (bus2.stall !== 1'b0) begin errors++; $display("FAIL lu2_release: got %0b expected 0", bus2.stall); end
    checks++; if (bus2.fwd_a !== 2'b11) begin errors++; $display("FAIL lu2_fwd_wb: got %b expected 11", bus2.fwd_a); end
    checks++; if (bus2.stall_cnt !== 16'd2) begin errors++; $display("FAIL lu2_cnt: got %0d expected 2", bus2.stall_cnt); end
  endtask

  task automatic test_x0_priority();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    next_cycle();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0);
    #1;
    checks++; if ({bus1.fwd_a, bus1.fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_nomatch: got %b%b expected 0000", bus1.fwd_a, bus1.fwd_b); end
    next_cycle();
    next_cycle();
    set_id(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus1.fwd_a !== 2'b01) begin errors++; $display("FAIL prio_ex_a: got %b expected 01", bus1.fwd_a); end
    checks++; if (bus1.fwd_b !== 2'b01) begin errors++; $display("FAIL prio_ex_b: got %b expected 01", bus1.fwd_b); end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    #1;
    checks++; if (bus3.stall !== 1'b1) begin errors++; $display("FAIL br_stall1: got %0b expected 1", bus3.stall); end
    next_cycle();
    set_id(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0);
    #1;
    checks++; if (bus3.stall !== 1'b1) begin errors++; $display("FAIL br_stall2: got %0b expected 1", bus3.stall); end
    br_taken = 1'b1;
    #1;
    checks++; if ({bus3.stall, bus3.flush_if_id, bus3.bubble_ex} !== 3'b011) begin errors++; $display("FAIL br_override: got %b expected 011", {bus3.stall, bus3.flush_if_id, bus3.bubble_ex}); end
    next_cycle();
    br_taken = 1'b0;
    set_id(1'b1, 5'd9, 5'd7, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if (bus3.fwd_a !== 2'b00) begin errors++; $display("FAIL br_wrongpath_ex: got %b expected 00", bus3.fwd_a); end
    checks++; if (bus3.fwd_b !== 2'b11) begin errors++; $display("FAIL br_fwd_wb: got %b expected 11", bus3.fwd_b); end
    checks++; if ({bus3.stall, bus3.flush_if_id} !== 2'b00) begin errors++; $display("FAIL br_after: got %b expected 00", {bus3.stall, bus3.flush_if_id}); end
    next_cycle();
    #1;
    checks++; if (bus3.stall !== 1'b0) begin errors++; $display("FAIL br_fsm_run: got %0b expected 0", bus3.stall); end
    checks++; if (bus3.stall_cnt !== 16'd1) begin errors++; $display("FAIL br_cnt: got %0d expected 1", bus3.stall_cnt); end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    set_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1);
    next_cycle();
    set_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0);
    next_cycle();
    #1;
    checks++; if (bus3.stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0b expected 1", bus3.stall); end
    #1;
    rst = 1'b1;
    br_taken = 1'b1;
    #1;
    checks++; if ({bus3.stall, bus3.bubble_ex, bus3.flush_if_id} !== 3'b000) begin errors++; $display("FAIL rst_async_ctrl: got %b expected 000", {bus3.stall, bus3.bubble_ex, bus3.flush_if_id}); end
    checks++; if ({bus3.fwd_a, bus3.fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_async_fwd: got %b%b expected 0000", bus3.fwd_a, bus3.fwd_b); end
    checks++; if (bus3.stall_cnt !== 16'd0) begin errors++; $display("FAIL rst_async_cnt: got %0d expected 0", bus3.stall_cnt); end
    next_cycle();
    br_taken = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    set_id(1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0);
    #1;
    checks++; if ({bus3.fwd_a, bus3.fwd_b} !== 4'b0000) begin errors++; $display("FAIL rst_stale_fwd: got %b%b expected 0000", bus3.fwd_a, bus3.fwd_b); end
    checks++; if (bus3.stall !== 1'b0) begin errors++; $display("FAIL rst_post_stall: got %0b expected 0", bus3.stall); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_alu_chain();
    test_load_use_1();
    test_load_use_2();
    test_x0_priority();
    test_branch_in_stall();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
